// File: rtl/io_bridge.sv
// I/O bridge between the CPU external bus, the 128KB RAM and the local I/O block
// (RX/TX byte FIFOs, 32-bit cycle counter, program-stop flag).

module io_bridge_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module io_bridge #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam logic [17:0] ADDR_DATA = 18'h30000;
    localparam logic [17:0] ADDR_CNT0 = 18'h30004;
    localparam logic [17:0] ADDR_CNT1 = 18'h30005;
    localparam logic [17:0] ADDR_CNT2 = 18'h30006;
    localparam logic [17:0] ADDR_CNT3 = 18'h30007;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-9:0] snap_q, snap_d;
    logic             sel_io_q, sel_io_d;
    logic [7:0]       io_rdata_q, io_rdata_d;
    logic             rd_live_q, rd_live_d;
    logic             stop_q, stop_d;
    logic             ovf_q, ovf_d;

    logic        io;
    logic [17:0] addr;
    logic        rd_io;
    logic        wr_io;
    logic [7:0]  io_rval;
    logic        rx_pop;
    logic        rx_push;
    logic [7:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic        tx_req;
    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_wdata;
    logic        tx_full;
    logic        tx_empty;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^cpu_a[31:18];

    assign addr     = cpu_a[17:0];
    assign io       = (cpu_a[17:16] == 2'b11);
    assign rd_io    = rdy_in & ~cpu_wr & io;
    assign wr_io    = rdy_in & cpu_wr & io;

    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_wr   = cpu_wr & ~io & rdy_in;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;

    // rd_live_q keeps cpu_din at zero until the first bus cycle after reset.
    assign cpu_din      = ~rd_live_q ? 8'h00 : (sel_io_q ? io_rdata_q : ram_din);
    assign program_stop = stop_q;
    assign tx_overflow  = ovf_q;

    io_bridge_fifo #(.AW(FIFO_AW), .DW(8)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    io_bridge_fifo #(.AW(FIFO_AW), .DW(8)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_wdata),
        .head  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // An empty RX FIFO reads as 0x00 through rx_head; the FIFO ignores the pop.
    always_comb begin
        io_rval = 8'h00;
        snap_d  = snap_q;
        rx_pop  = 1'b0;
        if (rd_io) begin
            case (addr)
                ADDR_DATA: begin
                    io_rval = rx_head;
                    rx_pop  = 1'b1;
                end
                ADDR_CNT0: begin
                    io_rval = cnt_q[7:0];
                    snap_d  = cnt_q[CNT_W-1:8];
                end
                ADDR_CNT1: io_rval = snap_q[7:0];
                ADDR_CNT2: io_rval = snap_q[15:8];
                ADDR_CNT3: io_rval = snap_q[23:16];
                default:   io_rval = 8'h00;
            endcase
        end
    end

    always_comb begin
        tx_req   = 1'b0;
        tx_wdata = cpu_dout;
        stop_d   = stop_q;
        if (wr_io) begin
            if (addr == ADDR_DATA && cpu_dout != 8'h00) begin
                tx_req = 1'b1;
            end else if (addr == ADDR_CNT0) begin
                tx_req   = 1'b1;
                tx_wdata = 8'h00;
                stop_d   = 1'b1;
            end
        end
        tx_push = tx_req & (~tx_full | tx_pop);
        ovf_d   = ovf_q | (tx_req & tx_full & ~tx_pop);
    end

    always_comb begin
        cnt_d      = cnt_q;
        sel_io_d   = sel_io_q;
        io_rdata_d = io_rdata_q;
        rd_live_d  = rd_live_q;
        if (rdy_in) begin
            cnt_d      = cnt_q + CNT_W'(1);
            sel_io_d   = io;
            io_rdata_d = io_rval;
            rd_live_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            snap_q     <= '0;
            sel_io_q   <= 1'b0;
            io_rdata_q <= 8'h00;
            rd_live_q  <= 1'b0;
            stop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            sel_io_q   <= sel_io_d;
            io_rdata_q <= io_rdata_d;
            rd_live_q  <= rd_live_d;
            stop_q     <= stop_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: directed bring-up sequence followed by randomized traffic,
// all compared against a queue-based reference model of the bus and I/O map.

module tb_io_bridge;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic [16:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        program_stop;
   logic        tx_overflow;

   int checks = 0;
   int failures = 0;

   // Bench-side RAM driven purely by the DUT's RAM port.
   logic [7:0] ramMem [131072];

   // Reference model state.
   logic [7:0]  mRam [131072];
   logic [7:0]  mRxQ [$];
   logic [7:0]  mTxQ [$];
   logic [31:0] mCnt;
   logic [23:0] mSnap;
   bit          mSel;
   logic [7:0]  mRdata;
   bit          mLive;
   bit          mStop;
   bit          mOvf;
   logic [7:0]  mRamExp;

   io_bridge #(.FIFO_AW(4), .CNT_W(32)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .cpu_a        (cpu_a),
      .cpu_dout     (cpu_dout),
      .cpu_wr       (cpu_wr),
      .cpu_din      (cpu_din),
      .ram_a        (ram_a),
      .ram_wr       (ram_wr),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .program_stop (program_stop),
      .tx_overflow  (tx_overflow)
   );

   // 100 MHz-style free-running clock.
   always #5 clk_in = ~clk_in;

   // Synchronous RAM with one-cycle read latency, read-before-write.
   always @(posedge clk_in) begin
      if (ram_wr) ramMem[ram_a] <= ram_dout;
      ram_din <= ramMem[ram_a];
   end

   function automatic logic [7:0] initVal(input int i);
      logic [31:0] v;
      v = i;
      return v[7:0] ^ v[15:8] ^ 8'h5A;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advances the reference model by one clock from the spec's rules.
   task automatic modelStep(input bit rst, input bit rdy, input logic [31:0] a, input logic [7:0] d,
                            input bit wr, input logic [7:0] rxd, input bit rxv, input bit txr);
      bit          io;
      logic [17:0] ad;
      logic [7:0]  rv;
      bit          rxAcc;
      bit          txPop;
      bit          txReq;
      logic [7:0]  txByte;
      io = (a[17:16] == 2'b11);
      ad = a[17:0];
      mRamExp = mRam[a[16:0]];
      if (wr && !io && rdy) mRam[a[16:0]] = d;
      if (rst) begin
         mRxQ.delete();
         mTxQ.delete();
         mCnt = 0;
         mSnap = 0;
         mSel = 0;
         mRdata = 0;
         mLive = 0;
         mStop = 0;
         mOvf = 0;
         return;
      end
      rxAcc = rxv && (mRxQ.size() < 16);
      txPop = txr && (mTxQ.size() > 0);
      rv = 8'h00;
      if (rdy && !wr && io) begin
         case (ad)
            18'h30000: if (mRxQ.size() > 0) rv = mRxQ.pop_front();
            18'h30004: begin
               rv = mCnt[7:0];
               mSnap = mCnt[31:8];
            end
            18'h30005: rv = mSnap[7:0];
            18'h30006: rv = mSnap[15:8];
            18'h30007: rv = mSnap[23:16];
            default:   rv = 8'h00;
         endcase
      end
      txReq = 0;
      txByte = d;
      if (rdy && wr && io) begin
         if (ad == 18'h30000 && d != 8'h00) txReq = 1;
         if (ad == 18'h30004) begin
            txReq = 1;
            txByte = 8'h00;
            mStop = 1;
         end
      end
      if (txPop) void'(mTxQ.pop_front());
      if (txReq) begin
         if (mTxQ.size() < 16) mTxQ.push_back(txByte);
         else mOvf = 1;
      end
      if (rxAcc) mRxQ.push_back(rxd);
      if (rdy) begin
         mSel = io;
         mRdata = rv;
         mLive = 1;
         mCnt = mCnt + 1;
      end
   endtask

   // Drives one bus cycle, steps the model and compares every output after the edge.
   task automatic applyStimulus(input bit rst, input bit rdy, input logic [31:0] a, input logic [7:0] d,
                                input bit wr, input logic [7:0] rxd, input bit rxv, input bit txr);
      logic [7:0] expDin;
      bit         io;
      rst_in   = rst;
      rdy_in   = rdy;
      cpu_a    = a;
      cpu_dout = d;
      cpu_wr   = wr;
      rx_data  = rxd;
      rx_valid = rxv;
      tx_ready = txr;
      io = (a[17:16] == 2'b11);
      modelStep(rst, rdy, a, d, wr, rxd, rxv, txr);
      @(posedge clk_in);
      #1;
      expDin = !mLive ? 8'h00 : (mSel ? mRdata : mRamExp);
      checkOutput("cpu_din", cpu_din, expDin);
      checkOutput("ram_a", ram_a, a[16:0]);
      checkOutput("ram_dout", ram_dout, d);
      checkOutput("ram_wr", ram_wr, wr && !io && rdy);
      checkOutput("rx_ready", rx_ready, mRxQ.size() < 16);
      checkOutput("tx_valid", tx_valid, mTxQ.size() > 0);
      if (mTxQ.size() > 0) checkOutput("tx_data", tx_data, mTxQ[0]);
      checkOutput("program_stop", program_stop, mStop);
      checkOutput("tx_overflow", tx_overflow, mOvf);
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  d;
      int          r;
      for (int i = 0; i < 131072; i++) begin
         ramMem[i] = initVal(i);
         mRam[i] = initVal(i);
      end

      // Reset overrides rdy_in and a pending RX byte.
      applyStimulus(1, 1, 32'h0, 8'h00, 0, 8'hAA, 1, 0);
      checkOutput("rst_cpu_din", cpu_din, 8'h00);
      checkOutput("rst_rx_ready", rx_ready, 1);
      checkOutput("rst_tx_valid", tx_valid, 0);

      // Counter reads as a consistent little-endian dword.
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h00, 0, 0);
      applyStimulus(0, 1, 32'h30004, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("cnt_b0", cpu_din, 8'h0A);
      applyStimulus(0, 1, 32'h30005, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("cnt_b1", cpu_din, 8'h00);
      applyStimulus(0, 1, 32'h30006, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("cnt_b2", cpu_din, 8'h00);
      applyStimulus(0, 1, 32'h30007, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("cnt_b3", cpu_din, 8'h00);

      // RX bytes come back in order, then an empty read gives zero.
      applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h41, 1, 0);
      applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h42, 1, 0);
      applyStimulus(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("rx_first", cpu_din, 8'h41);
      applyStimulus(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("rx_second", cpu_din, 8'h42);
      applyStimulus(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("rx_empty", cpu_din, 8'h00);
      checkOutput("rx_ready_hold", rx_ready, 1);

      // TX queueing skips zero bytes.
      applyStimulus(0, 1, 32'h30000, 8'h48, 1, 8'h00, 0, 0);
      applyStimulus(0, 1, 32'h30000, 8'h00, 1, 8'h00, 0, 0);
      applyStimulus(0, 1, 32'h30000, 8'h49, 1, 8'h00, 0, 0);
      checkOutput("tx_valid_48", tx_valid, 1);
      checkOutput("tx_head_48", tx_data, 8'h48);
      applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h00, 0, 1);
      checkOutput("tx_head_49", tx_data, 8'h49);
      applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h00, 0, 1);
      checkOutput("tx_drained", tx_valid, 0);

      // TX full: simultaneous pop admits a write, otherwise it is dropped.
      for (int i = 1; i <= 16; i++) applyStimulus(0, 1, 32'h30000, 8'(i), 1, 8'h00, 0, 0);
      applyStimulus(0, 1, 32'h30000, 8'h77, 1, 8'h00, 0, 1);
      checkOutput("full_pop_ovf", tx_overflow, 0);
      checkOutput("full_pop_head", tx_data, 8'h02);
      applyStimulus(0, 1, 32'h30000, 8'h78, 1, 8'h00, 0, 0);
      checkOutput("full_drop_ovf", tx_overflow, 1);
      checkOutput("full_drop_head", tx_data, 8'h02);
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h00, 0, 1);
      checkOutput("full_drained", tx_valid, 0);

      // RAM pass-through and I/O writes kept off the RAM.
      applyStimulus(0, 1, 32'h01234, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("ram_rd_addr", ram_a, 17'h01234);
      checkOutput("ram_rd_wr", ram_wr, 0);
      checkOutput("ram_rd_data", cpu_din, 8'h7C);
      applyStimulus(0, 1, 32'h30000, 8'h55, 1, 8'h00, 0, 0);
      checkOutput("io_wr_no_ram", ram_wr, 0);
      applyStimulus(0, 1, 32'h00555, 8'hA5, 1, 8'h00, 0, 1);
      checkOutput("ram_wr_strobe", ram_wr, 1);
      applyStimulus(0, 1, 32'h00555, 8'h00, 0, 8'h00, 0, 1);
      checkOutput("ram_readback", cpu_din, 8'hA5);

      // rdy_in low freezes CPU-side side effects.
      applyStimulus(0, 1, 32'h0, 8'h00, 0, 8'h33, 1, 0);
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 32'h30000, 8'h66, (i % 2) == 1, 8'h00, 0, 0);
      checkOutput("frz_no_push", tx_valid, 0);
      applyStimulus(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("frz_no_pop", cpu_din, 8'h33);
      applyStimulus(0, 1, 32'h30004, 8'hFF, 1, 8'h00, 0, 0);
      checkOutput("stop_set", program_stop, 1);
      checkOutput("stop_tx_zero", tx_data, 8'h00);
      checkOutput("stop_tx_valid", tx_valid, 1);
      applyStimulus(1, 0, 32'h0, 8'h00, 0, 8'h00, 0, 0);
      checkOutput("rst2_stop", program_stop, 0);
      checkOutput("rst2_ovf", tx_overflow, 0);
      checkOutput("rst2_tx_valid", tx_valid, 0);
      checkOutput("rst2_cpu_din", cpu_din, 8'h00);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         if (r <= 3) a[17:0] = 18'h30000;
         else if (r == 4) a[17:0] = 18'h30004;
         else if (r == 5) a[17:0] = 18'h30004 + 18'($urandom_range(1, 3));
         else if (r == 6) a[17:0] = 18'h30000 + 18'($urandom_range(8, 16'hFFFF));
         else if (a[17:16] == 2'b11) a[17] = 1'b0;
         d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, a, d,
                       $urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) < 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
